// File: rtl/complex_dot_pkg.sv
// Shared helpers, derived sizes and FSM encoding for the streaming complex dot-product engine.
package complex_dot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
        return (n + d - 1) / d;
    endfunction

    // Beats needed to carry one vector.
    function automatic int unsigned beats_of(input int unsigned noe, input int unsigned lanes);
        return ceil_div(noe, lanes);
    endfunction

    // Overflow-free width of one result component.
    function automatic int unsigned res_w_of(input int unsigned comp_w, input int unsigned noe);
        return 2 * comp_w + clog2(2 * noe) + 1;
    endfunction

    // Beat counter width, never below one bit.
    function automatic int unsigned cnt_w_of(input int unsigned beats);
        return (beats > 1) ? clog2(beats) : 1;
    endfunction

    // Bit offset of the real half of a lane element (real sits in the upper half).
    function automatic int unsigned re_lsb(input int unsigned lane, input int unsigned comp_w);
        return lane * 2 * comp_w + comp_w;
    endfunction

    // Bit offset of the imaginary half of a lane element.
    function automatic int unsigned im_lsb(input int unsigned lane, input int unsigned comp_w);
        return lane * 2 * comp_w;
    endfunction

endpackage

// File: rtl/complex_mac_lane.sv
// One complex multiply lane: pad zeroing, optional conjugation of A, registered product pair.
module complex_mac_lane #(
    parameter int unsigned COMP_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_i,
    input  logic                       keep_i,
    input  logic                       conj_i,
    input  logic signed [COMP_W-1:0]   a_re_i,
    input  logic signed [COMP_W-1:0]   a_im_i,
    input  logic signed [COMP_W-1:0]   b_re_i,
    input  logic signed [COMP_W-1:0]   b_im_i,
    output logic signed [2*COMP_W:0]   p_re_o,
    output logic signed [2*COMP_W:0]   p_im_o
);

    localparam int unsigned P_W = 2 * COMP_W;
    localparam int unsigned S_W = 2 * COMP_W + 1;

    logic signed [COMP_W-1:0] ar_c, ai_c, br_c, bi_c;
    logic signed [P_W-1:0]    rr_c, ii_c, ri_c, ir_c;
    logic signed [S_W-1:0]    re_d, im_d, re_q, im_q;

    // Zero padded lanes, form the four partial products and combine with conj sign.
    always_comb begin
        ar_c = keep_i ? a_re_i : '0;
        ai_c = keep_i ? a_im_i : '0;
        br_c = keep_i ? b_re_i : '0;
        bi_c = keep_i ? b_im_i : '0;
        rr_c = P_W'(ar_c) * P_W'(br_c);
        ii_c = P_W'(ai_c) * P_W'(bi_c);
        ri_c = P_W'(ar_c) * P_W'(bi_c);
        ir_c = P_W'(ai_c) * P_W'(br_c);
        if (conj_i) begin
            re_d = S_W'(rr_c) + S_W'(ii_c);
            im_d = S_W'(ri_c) - S_W'(ir_c);
        end else begin
            re_d = S_W'(rr_c) - S_W'(ii_c);
            im_d = S_W'(ri_c) + S_W'(ir_c);
        end
    end

    // Product register, loaded once per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_q <= '0;
            im_q <= '0;
        end else if (en_i) begin
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    assign p_re_o = re_q;
    assign p_im_o = im_q;

endmodule

// File: rtl/complex_vector_dot_stream.sv
// Streaming complex dot product: LANES elements per beat, full-precision accumulate, held result.
module complex_vector_dot_stream
    import complex_dot_pkg::*;
#(
    parameter int unsigned NOE    = 16,
    parameter int unsigned LANES  = 8,
    parameter int unsigned COMP_W = 32
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    conj_a,
    input  logic [2*COMP_W*LANES-1:0]               a_vec,
    input  logic [2*COMP_W*LANES-1:0]               b_vec,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [2*res_w_of(COMP_W, NOE)-1:0]      result,
    output logic                                    busy
);

    localparam int unsigned BEATS = beats_of(NOE, LANES);
    localparam int unsigned CNT_W = cnt_w_of(BEATS);
    localparam int unsigned RES_W = res_w_of(COMP_W, NOE);
    localparam int unsigned S_W   = 2 * COMP_W + 1;
    localparam int unsigned VEC_W = 2 * COMP_W * LANES;

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 in_ready_q, out_valid_q, busy_q;

    logic [VEC_W-1:0]     a_q, b_q;
    logic [CNT_W-1:0]     beat_q;
    logic                 v0_q, first0_q, last0_q, conj_q;
    logic                 v1_q, first1_q, last1_q;

    logic signed [RES_W-1:0] acc_re_q, acc_im_q;
    logic signed [RES_W-1:0] sum_re_c, sum_im_c;
    logic [LANES-1:0]        keep_c;
    logic signed [S_W-1:0]   p_re_c [LANES];
    logic signed [S_W-1:0]   p_im_c [LANES];

    logic accept_c;
    logic last_beat_c;

    assign accept_c    = in_valid && in_ready_q;
    assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

    // Control FSM with registered handshake and busy outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: begin
                    in_ready_q <= 1'b1;
                    if (accept_c) begin
                        busy_q <= 1'b1;
                        if (last_beat_c) begin
                            state_q    <= ST_DRAIN;
                            in_ready_q <= 1'b0;
                            cnt_q      <= '0;
                        end else begin
                            state_q <= ST_LOAD;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (v1_q && last1_q) begin
                        state_q     <= ST_HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Input stage: capture beat data, its index and the vector-level conj flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q      <= '0;
            b_q      <= '0;
            beat_q   <= '0;
            v0_q     <= 1'b0;
            first0_q <= 1'b0;
            last0_q  <= 1'b0;
            conj_q   <= 1'b0;
        end else begin
            v0_q <= accept_c;
            if (accept_c) begin
                a_q      <= a_vec;
                b_q      <= b_vec;
                beat_q   <= cnt_q;
                first0_q <= (cnt_q == '0);
                last0_q  <= last_beat_c;
                if (cnt_q == '0) conj_q <= conj_a;
            end
        end
    end

    // Lanes whose global element index falls past NOE are padding.
    always_comb begin
        keep_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            keep_c[i] = ((32'(beat_q) * LANES) + i) < NOE;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        complex_mac_lane #(.COMP_W(COMP_W)) u_lane (
            .clk    (clk),
            .rst_n  (reset),
            .en_i   (v0_q),
            .keep_i (keep_c[i]),
            .conj_i (conj_q),
            .a_re_i (a_q[re_lsb(i, COMP_W) +: COMP_W]),
            .a_im_i (a_q[im_lsb(i, COMP_W) +: COMP_W]),
            .b_re_i (b_q[re_lsb(i, COMP_W) +: COMP_W]),
            .b_im_i (b_q[im_lsb(i, COMP_W) +: COMP_W]),
            .p_re_o (p_re_c[i]),
            .p_im_o (p_im_c[i])
        );
    end

    // Sign-extended sum of all lane products.
    always_comb begin
        sum_re_c = '0;
        sum_im_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_re_c = sum_re_c + RES_W'(p_re_c[i]);
            sum_im_c = sum_im_c + RES_W'(p_im_c[i]);
        end
    end

    // Product-stage tags and accumulator; the first beat restarts the sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            acc_re_q <= '0;
            acc_im_q <= '0;
        end else begin
            v1_q     <= v0_q;
            first1_q <= first0_q;
            last1_q  <= last0_q;
            if (v1_q) begin
                acc_re_q <= first1_q ? sum_re_c : acc_re_q + sum_re_c;
                acc_im_q <= first1_q ? sum_im_c : acc_im_q + sum_im_c;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = {acc_re_q, acc_im_q};

endmodule

// File: tb/tb_complex_vector_dot_stream.sv
// Directed self-checking bench: NOE=16 and NOE=12 instances, LANES=8, COMP_W=32.
module tb_complex_vector_dot_stream;

    localparam int unsigned VW = 512;
    localparam int unsigned RW = 70;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          iv16, cj16, or16, ir16, ov16, bz16;
    logic [VW-1:0] a16, b16;
    logic [2*RW-1:0] res16;

    logic          iv12, cj12, or12, ir12, ov12, bz12;
    logic [VW-1:0] a12, b12;
    logic [2*RW-1:0] res12;

    int checks = 0;
    int errors = 0;

    complex_vector_dot_stream #(.NOE(16), .LANES(8), .COMP_W(32)) dut16 (
        .clk(clk), .reset(rst_n), .in_valid(iv16), .in_ready(ir16), .conj_a(cj16),
        .a_vec(a16), .b_vec(b16), .out_valid(ov16), .out_ready(or16),
        .result(res16), .busy(bz16)
    );

    complex_vector_dot_stream #(.NOE(12), .LANES(8), .COMP_W(32)) dut12 (
        .clk(clk), .reset(rst_n), .in_valid(iv12), .in_ready(ir12), .conj_a(cj12),
        .a_vec(a12), .b_vec(b12), .out_valid(ov12), .out_ready(or12),
        .result(res12), .busy(bz12)
    );

    function automatic logic [63:0] el(input int re, input int im);
        return {re, im};
    endfunction

    function automatic logic [VW-1:0] fill(input int re, input int im);
        logic [VW-1:0] v;
        for (int i = 0; i < 8; i++) v[i*64 +: 64] = el(re, im);
        return v;
    endfunction

    function automatic logic [2*RW-1:0] cres(input longint re, input longint im);
        return {RW'(re), RW'(im)};
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input logic [2*RW-1:0] obs, input logic [2*RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat from a negedge, wait (bounded) for ready, return at the next negedge.
    task automatic beat(input bit d12, input logic [VW-1:0] a, input logic [VW-1:0] b, input logic cj);
        int n;
        n = 0;
        if (d12) begin iv12 = 1'b1; a12 = a; b12 = b; cj12 = cj; end
        else     begin iv16 = 1'b1; a16 = a; b16 = b; cj16 = cj; end
        while (((d12 ? ir12 : ir16) !== 1'b1) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_bit("beat_ready", d12 ? ir12 : ir16, 1'b1);
        @(posedge clk);
        @(negedge clk);
        if (d12) iv12 = 1'b0; else iv16 = 1'b0;
    endtask

    // One output handshake cycle.
    task automatic consume(input bit d12);
        if (d12) or12 = 1'b1; else or16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (d12) or12 = 1'b0; else or16 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] va, vb;
        logic [RW-1:0] big;
        int m;

        rst_n = 1'b0;
        iv16 = 0; cj16 = 0; or16 = 0; a16 = '0; b16 = '0;
        iv12 = 0; cj12 = 0; or12 = 0; a12 = '0; b12 = '0;
        @(negedge clk);
        @(negedge clk);
        chk_bit("rst_in_ready", ir16, 1'b0);
        chk_bit("rst_out_valid", ov16, 1'b0);
        chk_bit("rst_busy", bz16, 1'b0);
        chk_res("rst_result", res16, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_bit("idle_ready", ir16, 1'b1);
        chk_bit("idle_busy", bz16, 1'b0);

        // Plain product, back-to-back beats, exact latency.
        beat(0, fill(1, 1), fill(2, -1), 1'b0);
        chk_bit("s1_load_ready", ir16, 1'b1);
        chk_bit("s1_busy", bz16, 1'b1);
        beat(0, fill(1, 1), fill(2, -1), 1'b0);
        chk_bit("s1_e0_valid", ov16, 1'b0);
        chk_bit("s1_e0_ready", ir16, 1'b0);
        @(negedge clk);
        chk_bit("s1_e1_valid", ov16, 1'b0);
        @(negedge clk);
        chk_bit("s1_e2_valid", ov16, 1'b1);
        chk_res("s1_result", res16, cres(48, 16));
        chk_bit("s1_hold_ready", ir16, 1'b0);
        consume(0);
        chk_bit("s1_post_valid", ov16, 1'b0);
        chk_bit("s1_post_ready", ir16, 1'b1);
        chk_bit("s1_post_busy", bz16, 1'b0);

        // Conjugate A; toggling conj on beat 1 must be ignored.
        beat(0, fill(1, 1), fill(2, -1), 1'b1);
        beat(0, fill(1, 1), fill(2, -1), 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_bit("s2_valid", ov16, 1'b1);
        chk_res("s2_result", res16, cres(16, -48));
        consume(0);

        // NOE=12: padded lanes 4..7 of beat 1 carry junk.
        beat(1, fill(1, 1), fill(1, 1), 1'b0);
        va = fill(1, 1);
        for (int i = 4; i < 8; i++) va[i*64 +: 64] = el(7, 7);
        beat(1, va, va, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_bit("s3_valid", ov12, 1'b1);
        chk_bit("s3_busy", bz12, 1'b1);
        chk_res("s3_result", res12, cres(0, 24));
        consume(1);
        chk_bit("s3_post_valid", ov12, 1'b0);

        // Input gap of 3 cycles, then output back-pressure for 5 cycles.
        beat(0, fill(3, -2), fill(-1, 4), 1'b0);
        repeat (3) @(negedge clk);
        chk_bit("s4_gap_ready", ir16, 1'b1);
        chk_bit("s4_gap_valid", ov16, 1'b0);
        beat(0, fill(3, -2), fill(-1, 4), 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_bit("s4_valid", ov16, 1'b1);
        chk_res("s4_result", res16, cres(80, 224));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_bit("s4_hold_valid", ov16, 1'b1);
            chk_bit("s4_hold_ready", ir16, 1'b0);
            chk_res("s4_hold_result", res16, cres(80, 224));
        end
        consume(0);
        chk_bit("s4_post_valid", ov16, 1'b0);
        chk_bit("s4_post_ready", ir16, 1'b1);

        // Per-lane distinct data: beat0 real k, beat1 imaginary k, conjugated.
        va = '0;
        vb = fill(1, 0);
        for (int i = 0; i < 8; i++) va[i*64 +: 64] = el(i + 1, 0);
        beat(0, va, vb, 1'b1);
        for (int i = 0; i < 8; i++) va[i*64 +: 64] = el(0, i + 1);
        beat(0, va, vb, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk_bit("s5_valid", ov16, 1'b1);
        chk_res("s5_result", res16, cres(36, -36));
        consume(0);

        // Full-negative components under conjugation: 16 * 2^63, no wrap.
        m = int'(32'h8000_0000);
        beat(0, fill(m, m), fill(m, m), 1'b1);
        beat(0, fill(m, m), fill(m, m), 1'b1);
        @(negedge clk);
        @(negedge clk);
        big = RW'(1) << 67;
        chk_bit("s6_valid", ov16, 1'b1);
        chk_res("s6_result", res16, {big, RW'(0)});
        consume(0);

        // Reset after beat 0 discards the partial vector.
        beat(0, fill(5, 5), fill(5, 5), 1'b0);
        rst_n = 1'b0;
        #1;
        chk_bit("s7_rst_ready", ir16, 1'b0);
        chk_bit("s7_rst_valid", ov16, 1'b0);
        chk_bit("s7_rst_busy", bz16, 1'b0);
        chk_res("s7_rst_result", res16, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_bit("s7_idle_valid", ov16, 1'b0);
        beat(0, fill(1, 1), fill(2, -1), 1'b0);
        beat(0, fill(1, 1), fill(2, -1), 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_bit("s7_valid", ov16, 1'b1);
        chk_res("s7_result", res16, cres(48, 16));
        consume(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/complex_vector_dot_stream.md
Name: complex_vector_dot_stream

Overview:
- Parametrised streaming complex dot-product engine: next generation of the single-configuration vector×vector block.
- Accepts one vector pair as ceil(NOE/LANES) beats of LANES complex elements each, under valid/ready handshake.
- Lanes past NOE are zero-padded internally; optional conjugation of operand A gives a Hermitian inner product.
- Returns one full-precision complex result with valid/ready hold; sits between the row/vector memories and the solver control.

Parameters:
- NOE, 16, elements per vector (≥1).
- LANES, 8, complex elements per beat (≥1).
- COMP_W, 32, signed width of each real/imag component; element width is 2*COMP_W.
- BEATS, ceil(NOE/LANES), derived, beats per vector.
- RES_W, 2*COMP_W+clog2(2*NOE)+1, derived, width of each result component; overflow-free.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat on a_vec/b_vec is valid.
- in_ready  out  1  engine accepts a beat this cycle.
- conj_a  in  1  conjugate A; sampled on the first beat of each vector.
- a_vec  in  2*COMP_W*LANES  operand A lanes; lane i at bits [(i+1)*2*COMP_W-1 : i*2*COMP_W], real in upper half, imag in lower half, two's complement.
- b_vec  in  2*COMP_W*LANES  operand B lanes, same packing.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer takes result.
- result  out  2*RES_W  {re, im} sum over k of A'[k]*B[k]; A' = conj(A) if conj_a else A.
- busy  out  1  high from first accepted beat until result consumed.

Behaviour:
- Reset (reset=0, async): state=IDLE; in_ready=0, out_valid=0, busy=0, result=0; beat counter, pipeline registers and accumulator cleared. Reset mid-vector discards the partial sum; no result is produced.
- FSM states:
  - IDLE: in_ready=1.
  - LOAD: in_ready=1, beats 1..BEATS-1.
  - DRAIN: in_ready=0, pipeline flushing.
  - HOLD: out_valid=1.
- Transitions:
  - IDLE→LOAD on first beat; IDLE→DRAIN directly if BEATS=1.
  - LOAD→DRAIN when beat BEATS-1 is accepted.
  - DRAIN→HOLD when the accumulator holds the final sum.
  - HOLD→IDLE on out_valid&&out_ready.
- Beat accepted when in_valid&&in_ready. in_valid gaps in LOAD stall without corrupting the count.
- Padding: global index g = beat*LANES+lane. Lanes with g ≥ NOE are forced to zero before multiplication, whatever the input data.
- Pipeline:
  - Edge E: beat accepted into input registers.
  - E+1: lane products registered.
    - re = ar*br - s*ai*bi, im = ar*bi + s*ai*br, where s = +1 normally.
    - Under conj: re = ar*br + ai*bi, im = ar*bi - ai*br.
  - E+2: adder-tree sum added into the accumulator. The accumulator is cleared, not added to, on the first beat of a vector.
- Latency: last beat accepted at edge E → out_valid high after edge E+2. result is stable while out_valid=1.
- conj_a is latched on beat 0; changes on later beats are ignored.
- in_ready stays 0 from the final beat until the cycle after the output handshake. No same-cycle overlap of result consume and new beat accept.
- out_ready while out_valid=0 is ignored.
- Arithmetic: all signed, sign-extended to RES_W, no rounding, no saturation. Full-negative inputs (-2^(COMP_W-1)) must not overflow.

Decomposition:
- Package complex_dot_pkg:
  - clog2 and ceil_div functions.
  - Derived BEATS/RES_W expressions.
  - FSM state enum (IDLE, LOAD, DRAIN, HOLD).
  - Component field-extraction helpers.
- Sub-module complex_mac_lane:
  - One lane: pad-zeroing, conj select, 4 multipliers, registered product pair.
  - Instantiated LANES times.
  - Top keeps FSM, counter, adder tree and accumulator.

Test Plan:
- NOE=16, LANES=8, all A=(1,1), B=(2,-1), conj_a=0, 2 back-to-back beats → out_valid 3 cycles after beat 2 cycle; result re=48, im=16.
- Same data, conj_a=1 → re=16, im=-48; toggling conj_a on beat 2 has no effect.
- NOE=12, LANES=8, lanes 4..7 of beat 1 driven to (7,7) → those lanes are ignored; only 12 products summed (all-ones inputs, conj_a=0 → re=0, im=24).
- in_valid gap of 3 cycles between beats plus out_ready held low 5 cycles → result unchanged and out_valid held; in_ready=0 until one cycle after the handshake.
- All elements (-2^(COMP_W-1), -2^(COMP_W-1)), conj_a=1 → re = NOE*2^(2*COMP_W-1) exactly, im=0, no wrap.
- reset pulsed low after beat 0 → all outputs 0 immediately; next full vector (scenario 1 data) yields re=48, im=16 with no residue.
